// File: rtl/dma_dsc_cache_pkg.sv
// Shared types and default sizes for the descriptor cache read-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dma_dsc_cache_pkg;

   localparam int DSC_WIDTH   = 128;  // descriptor / cache word width
   localparam int DSC_ADDR_W  = 7;    // 128-entry cache
   localparam int DSC_NUM_REQ = 4;    // channel engines sharing the read port
   localparam int REQ_ID_W    = $clog2(DSC_NUM_REQ);

   typedef logic [REQ_ID_W-1:0] req_id_t;

   // One slot of the read-return pipeline. fwd/fwd_data carry a same-cycle
   // write value past the RAM when forwarding is built in.
   typedef struct packed {
      logic                 valid;
      req_id_t              id;
      logic                 fwd;
      logic [DSC_WIDTH-1:0] fwd_data;
   } dsc_stage_t;

endpackage

// File: rtl/dma_dsc_cache_arb_if.sv
// Bundle of requester, fetch-engine write and cache RAM signals for dma_dsc_cache_arb.
// Latency: n/a (wires only).
// Backpressure: reads wait in RD_REQ until RD_GNT; writes are never stalled.
// Modports: slave = arbiter view, master = requesters/fetch engine/RAM view.
interface dma_dsc_cache_arb_if
   import dma_dsc_cache_pkg::*;
#(
   parameter int WIDTH   = DSC_WIDTH,
   parameter int ADDR_W  = DSC_ADDR_W,
   parameter int NUM_REQ = DSC_NUM_REQ
);
   logic                      WR_REQ;
   logic [ADDR_W-1:0]         WR_ADDR;
   logic [WIDTH-1:0]          WR_DATA;
   logic [NUM_REQ-1:0]        RD_REQ;
   logic [NUM_REQ*ADDR_W-1:0] RD_ADDR;
   logic [NUM_REQ-1:0]        RD_GNT;
   logic [NUM_REQ-1:0]        RD_VALID;
   logic [WIDTH-1:0]          RD_DATA;
   logic                      BUSY;
   logic                      RAM_WEN;
   logic [ADDR_W-1:0]         RAM_WADDR;
   logic [WIDTH-1:0]          RAM_WDATA;
   logic                      RAM_REN;
   logic [ADDR_W-1:0]         RAM_RADDR;
   logic [WIDTH-1:0]          RAM_RDATA;

   modport slave (
      input  WR_REQ, WR_ADDR, WR_DATA, RD_REQ, RD_ADDR, RAM_RDATA,
      output RD_GNT, RD_VALID, RD_DATA, BUSY,
             RAM_WEN, RAM_WADDR, RAM_WDATA, RAM_REN, RAM_RADDR
   );

   modport master (
      output WR_REQ, WR_ADDR, WR_DATA, RD_REQ, RD_ADDR, RAM_RDATA,
      input  RD_GNT, RD_VALID, RD_DATA, BUSY,
             RAM_WEN, RAM_WADDR, RAM_WDATA, RAM_REN, RAM_RADDR
   );

endinterface

// File: rtl/dma_dsc_rr_arbiter.sv
// Round-robin pick among NUM_REQ requests, searching from last_gnt+1 with wrap.
// Latency: combinational; the pointer register lives in the parent.
// Backpressure: none; the parent decides whether the pick becomes a grant.
// Ports: req in, last_gnt in, gnt one-hot out, idx out, vld (any request) out.
module dma_dsc_rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_gnt,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               vld
);

   // Position last_gnt+offs modulo NUM_REQ; offs never exceeds NUM_REQ.
   function automatic logic [IDX_W-1:0] rr_pos(input logic [IDX_W-1:0] base, input int offs);
      int p;
      p = int'(base) + offs;
      if (p >= NUM_REQ) p = p - NUM_REQ;
      return IDX_W'(p);
   endfunction

   always_comb begin
      gnt = '0;
      idx = '0;
      vld = 1'b0;
      // offs = NUM_REQ lands back on last_gnt itself, so it has lowest priority
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (!vld && req[rr_pos(last_gnt, i)]) begin
            vld                    = 1'b1;
            idx                    = rr_pos(last_gnt, i);
            gnt[rr_pos(last_gnt, i)] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dma_dsc_cache_arb.sv
// Descriptor cache read-port arbiter: round-robin read grants, write pass-through, tagged returns.
// Latency: grant in cycle T returns RD_VALID/RD_DATA in T+2; writes are combinational to the RAM.
// Backpressure: requesters hold RD_REQ/RD_ADDR until RD_GNT; writes never stall.
// Ports: CLOCK, RESET_N (sync, active-low), bus (dma_dsc_cache_arb_if.slave).
// Build option DSC_CACHE_WR_FWD_EN: forward a same-cycle write to a colliding read instead of stalling it.
module dma_dsc_cache_arb
   import dma_dsc_cache_pkg::*;
#(
   parameter int WIDTH   = DSC_WIDTH,
   parameter int ADDR_W  = DSC_ADDR_W,
   parameter int NUM_REQ = DSC_NUM_REQ
) (
   input logic               CLOCK,
   input logic               RESET_N,
   dma_dsc_cache_arb_if.slave bus
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W-1:0]   last_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic [NUM_REQ-1:0] arb_gnt;
   logic               arb_vld;
   logic [ADDR_W-1:0]  cand_addr;
   logic               collide;
   logic               fwd;
   logic               grant;
   dsc_stage_t         s1;
   dsc_stage_t         s2;

   // Write port: straight through, also during reset.
   assign bus.RAM_WEN   = bus.WR_REQ;
   assign bus.RAM_WADDR = bus.WR_ADDR;
   assign bus.RAM_WDATA = bus.WR_DATA;

   dma_dsc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req      (bus.RD_REQ),
      .last_gnt (last_gnt),
      .gnt      (arb_gnt),
      .idx      (arb_idx),
      .vld      (arb_vld)
   );

   always_comb begin
      cand_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_idx == IDX_W'(i)) cand_addr = bus.RD_ADDR[i*ADDR_W +: ADDR_W];
      end
   end

   // The RAM is read-first, so a read hitting this cycle's write would see stale data.
   assign collide = bus.WR_REQ && (cand_addr == bus.WR_ADDR);

`ifdef DSC_CACHE_WR_FWD_EN
   assign grant = RESET_N && arb_vld;
   assign fwd   = collide;
`else
   // Stall the whole port for a cycle; the pointer stays so the same requester retries first.
   assign grant = RESET_N && arb_vld && !collide;
   assign fwd   = 1'b0;
`endif

   assign bus.RD_GNT    = grant ? arb_gnt : '0;
   assign bus.RAM_REN   = grant;
   assign bus.RAM_RADDR = grant ? cand_addr : '0;

   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         last_gnt <= IDX_W'(NUM_REQ - 1);
         s1       <= '0;
         s2       <= '0;
      end else begin
         if (grant) last_gnt <= arb_idx;
         s1.valid    <= grant;
         s1.id       <= req_id_t'(arb_idx);
         s1.fwd      <= grant && fwd;
         s1.fwd_data <= (grant && fwd) ? bus.WR_DATA : '0;
         s2          <= s1;
      end
   end

   // Outputs are forced low during reset even before the first clock clears the stages.
   always_comb begin
      bus.RD_VALID = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (RESET_N && s2.valid && (s2.id == req_id_t'(i))) bus.RD_VALID[i] = 1'b1;
      end
   end

   assign bus.RD_DATA = (RESET_N && s2.valid) ? (s2.fwd ? s2.fwd_data : bus.RAM_RDATA) : '0;
   assign bus.BUSY    = RESET_N && (s1.valid || s2.valid);

endmodule

// File: tb/tb_dma_dsc_cache_arb.sv
// Bench for dma_dsc_cache_arb: directed scenarios plus random traffic against a transaction-level model.
// Latency: model expects returns two cycles after each grant.
// Backpressure: bench requesters hold request/address until granted, may withdraw at random.
module tb_dma_dsc_cache_arb;
   import dma_dsc_cache_pkg::*;

   localparam int W  = DSC_WIDTH;
   localparam int AW = DSC_ADDR_W;
   localparam int NR = DSC_NUM_REQ;

   typedef logic [W-1:0] word_t;
   typedef struct {
      int    due;
      int    id;
      word_t data;
   } ret_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dma_dsc_cache_arb_if bus_if ();

   dma_dsc_cache_arb dut (
      .CLOCK   (clk),
      .RESET_N (rst_n),
      .bus     (bus_if)
   );

   // Cache RAM: read-first, two registered read stages.
   word_t ram_mem [0:(1<<AW)-1];
   word_t ram_s1, ram_s2;
   always @(posedge clk) begin
      if (bus_if.RAM_WEN) ram_mem[bus_if.RAM_WADDR] <= bus_if.RAM_WDATA;
      if (bus_if.RAM_REN) ram_s1 <= ram_mem[bus_if.RAM_RADDR];
      ram_s2 <= ram_s1;
   end
   assign bus_if.RAM_RDATA = ram_s2;

   // Stimulus state
   logic          pend [NR];
   logic [AW-1:0] addr [NR];
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   word_t         wr_data;

   // Reference model state
   word_t ref_mem [0:(1<<AW)-1];
   int    last_gnt;
   ret_t  rq[$];
   int    cyc;

   int n_tests;
   int n_fail;

   logic [NR-1:0] obs_gnt, obs_vld;
   word_t         obs_data;
   logic          obs_busy;

   task automatic chk(input string tag, input word_t got, input word_t exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic apply();
      bus_if.WR_REQ  = wr_req;
      bus_if.WR_ADDR = wr_addr;
      bus_if.WR_DATA = wr_data;
      for (int i = 0; i < NR; i++) begin
         bus_if.RD_REQ[i]             = pend[i];
         bus_if.RD_ADDR[i*AW +: AW]   = addr[i];
      end
   endtask

   // One clock: drive, check at the falling edge against the model, advance the model.
   task automatic step();
      int            c;
      int            g;
      bit            coll;
      logic [NR-1:0] e_gnt, e_vld;
      word_t         e_data;
      logic [AW-1:0] e_raddr;
      logic          e_busy;
      apply();
      @(negedge clk);
      c = -1; g = -1; coll = 1'b0;
      if (rst_n) begin
         for (int k = 1; k <= NR; k++) begin
            int p = (last_gnt + k) % NR;
            if (c < 0 && pend[p]) c = p;
         end
         if (c >= 0) begin
            coll = wr_req && (addr[c] == wr_addr);
`ifdef DSC_CACHE_WR_FWD_EN
            g = c;
`else
            if (!coll) g = c;
`endif
         end
      end
      e_gnt = '0; e_raddr = '0;
      if (g >= 0) begin
         e_gnt[g] = 1'b1;
         e_raddr  = addr[g];
      end
      e_vld = '0; e_data = '0;
      if (rst_n && rq.size() > 0 && rq[0].due == cyc) begin
         e_vld[rq[0].id] = 1'b1;
         e_data          = rq[0].data;
      end
      e_busy = rst_n && (rq.size() > 0);

      obs_gnt  = bus_if.RD_GNT;
      obs_vld  = bus_if.RD_VALID;
      obs_data = bus_if.RD_DATA;
      obs_busy = bus_if.BUSY;

      chk("rd_gnt",    W'(bus_if.RD_GNT),    W'(e_gnt));
      chk("ram_ren",   W'(bus_if.RAM_REN),   W'(g >= 0));
      chk("ram_raddr", W'(bus_if.RAM_RADDR), W'(e_raddr));
      chk("rd_valid",  W'(bus_if.RD_VALID),  W'(e_vld));
      chk("rd_data",   bus_if.RD_DATA,       e_data);
      chk("busy",      W'(bus_if.BUSY),      W'(e_busy));
      chk("ram_wen",   W'(bus_if.RAM_WEN),   W'(wr_req));
      chk("ram_waddr", W'(bus_if.RAM_WADDR), W'(wr_addr));
      chk("ram_wdata", bus_if.RAM_WDATA,     wr_data);

      if (rst_n) begin
         if (rq.size() > 0 && rq[0].due == cyc) rq.delete(0);
         if (g >= 0) begin
            ret_t r;
            r.due  = cyc + 2;
            r.id   = g;
            r.data = coll ? wr_data : ref_mem[addr[g]];
            rq.push_back(r);
            last_gnt = g;
            pend[g]  = 1'b0;
         end
      end else begin
         rq.delete();
         last_gnt = NR - 1;
      end
      if (wr_req) ref_mem[wr_addr] = wr_data;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic rand_inputs();
      for (int i = 0; i < NR; i++) begin
         if (!pend[i]) begin
            if ($urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               addr[i] = AW'($urandom_range(0, 15));
            end
         end else if ($urandom_range(0, 15) == 0) begin
            pend[i] = 1'b0;
         end
      end
      wr_req  = $urandom_range(0, 1) == 1;
      wr_addr = AW'($urandom_range(0, 15));
      wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      rst_n   = $urandom_range(0, 63) != 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < NR; i++) pend[i] = 1'b0;
      wr_req = 1'b0;
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      word_t pat;
      n_tests  = 0;
      n_fail   = 0;
      cyc      = 0;
      last_gnt = NR - 1;
      rst_n    = 1'b0;
      wr_req   = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      for (int i = 0; i < NR; i++) begin
         pend[i] = 1'b0;
         addr[i] = '0;
      end

      // Reset with all requesters active; preload entries 0..15 meanwhile.
      for (int a = 0; a < 16; a++) begin
         for (int i = 0; i < NR; i++) begin
            pend[i] = 1'b1;
            addr[i] = AW'(i);
         end
         wr_req  = 1'b1;
         wr_addr = AW'(a);
         wr_data = {$urandom(), $urandom(), $urandom(), $urandom()};
         step();
         chk("rst_gnt_zero", W'(obs_gnt), '0);
      end

      // Release: requester 0 first, then rotation 1,2,3,0,... with returns two cycles later.
      rst_n  = 1'b1;
      wr_req = 1'b0;
      step();
      chk("first_gnt_req0", W'(obs_gnt), W'(4'b0001));
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < NR; i++) pend[i] = 1'b1;
         step();
         chk("rr_order", W'(obs_gnt), W'(1 << ((k + 1) % NR)));
         if (k >= 1) chk("rr_return", W'(obs_vld), W'(1 << ((k - 1) % NR)));
      end
      idle(3);

      // Single read of a freshly written entry.
      pat     = {16{8'hA5}};
      wr_req  = 1'b1;
      wr_addr = AW'(5);
      wr_data = pat;
      step();
      idle(1);
      pend[2] = 1'b1;
      addr[2] = AW'(5);
      step();
      chk("single_gnt", W'(obs_gnt), W'(4'b0100));
      step();
      step();
      chk("single_vld", W'(obs_vld), W'(4'b0100));
      chk("single_data", obs_data, pat);
      idle(2);

      // Read colliding with a same-cycle write to entry 9.
      pat     = {4{32'hC0111DE5}};
      pend[1] = 1'b1;
      addr[1] = AW'(9);
      wr_req  = 1'b1;
      wr_addr = AW'(9);
      wr_data = pat;
      step();
      wr_req = 1'b0;
`ifdef DSC_CACHE_WR_FWD_EN
      chk("coll_gnt_same", W'(obs_gnt), W'(4'b0010));
`else
      chk("coll_no_gnt", W'(obs_gnt), '0);
      step();
      chk("coll_gnt_retry", W'(obs_gnt), W'(4'b0010));
`endif
      step();
      step();
      chk("coll_vld", W'(obs_vld), W'(4'b0010));
      chk("coll_data", obs_data, pat);
      idle(2);

      // Reset one cycle after a grant: the read must never come back.
      pend[3] = 1'b1;
      addr[3] = AW'(3);
      step();
      chk("midrst_gnt", W'(obs_gnt), W'(4'b1000));
      rst_n = 1'b0;
      step();
      chk("midrst_busy_in_rst", W'(obs_busy), '0);
      rst_n = 1'b1;
      step();
      chk("midrst_no_vld", W'(obs_vld), '0);
      chk("midrst_busy", W'(obs_busy), '0);
      idle(2);

      // Random traffic with occasional resets.
      for (int k = 0; k < 600; k++) begin
         rand_inputs();
         step();
      end
      rst_n = 1'b1;
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
